// File: rtl/addsub_acc_pipe.sv
// rtl/addsub_acc_pipe.sv - 2-stage signed add/sub accumulator with valid/ready input and optional halt-on-overflow
// Define ADDSUB_ACC_SAT_EN to saturate S on ADD/SUB overflow instead of wrapping.
module addsub_acc_pipe #(
    parameter int WIDTH      = 8,
    parameter int CNT_WIDTH  = 8,
    parameter int HALT_ON_OF = 0
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 In_valid,
    output logic                 In_ready,
    input  logic [1:0]           Op,
    input  logic [WIDTH-1:0]     A,
    input  logic                 Clr_of,
    output logic [WIDTH-1:0]     S,
    output logic                 Out_valid,
    output logic                 OF,
    output logic                 OF_sticky,
    output logic [CNT_WIDTH-1:0] Count
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic             HALT_EN = (HALT_ON_OF != 0);
    localparam logic [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {RUN, HALT} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [1:0]       op_r;
    logic             v_r;

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             arith;
    logic             ovf_next;
    logic [WIDTH-1:0] s_next;
    logic             accept;

    // SUB is S + ~a + 1, so one overflow rule covers both: operands agree in sign, result differs.
    always_comb begin
        arith    = (op_r == OP_ADD) || (op_r == OP_SUB);
        b        = (op_r == OP_SUB) ? ~a_r : a_r;
        sum      = S + b + WIDTH'(op_r == OP_SUB);
        ovf_next = arith && (S[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != S[WIDTH-1]);
        s_next   = sum;
        case (op_r)
            OP_LOAD: s_next = a_r;
            OP_CLR:  s_next = '0;
            default: begin
`ifdef ADDSUB_ACC_SAT_EN
                if (ovf_next) begin
                    s_next = S[WIDTH-1] ? S_MIN : S_MAX;
                end
`endif
            end
        endcase
    end

    // Refusing the slot behind an overflowing op means nothing needs flushing on halt.
    assign In_ready = Resetn && (state == RUN) && !(HALT_EN && v_r && ovf_next);
    assign accept   = In_valid && In_ready;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state     <= RUN;
            a_r       <= '0;
            op_r      <= OP_ADD;
            v_r       <= 1'b0;
            S         <= '0;
            OF        <= 1'b0;
            OF_sticky <= 1'b0;
            Count     <= '0;
            Out_valid <= 1'b0;
        end else begin
            v_r       <= accept;
            Out_valid <= v_r;
            if (accept) begin
                a_r  <= A;
                op_r <= Op;
            end
            if (v_r) begin
                S     <= s_next;
                OF    <= ovf_next;
                Count <= (op_r == OP_CLR) ? '0 : Count + CNT_WIDTH'(1);
            end
            if (v_r && ovf_next) begin
                OF_sticky <= 1'b1;
            end else if (Clr_of) begin
                OF_sticky <= 1'b0;
            end
            case (state)
                RUN:     if (HALT_EN && v_r && ovf_next) state <= HALT;
                HALT:    if (Clr_of && !(v_r && ovf_next)) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// tb/tb_addsub_acc_pipe.sv - scoreboard bench: free-running and halt-on-overflow instances vs an integer reference model
module tb_addsub_acc_pipe;

    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LOAD = 2'd2, CLR = 2'd3;

    typedef struct {
        logic [7:0] s;
        logic       of;
        int         cnt;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] op_i = 2'd0;
    logic [7:0] a_i = 8'd0;
    logic       clr_of = 1'b0;

    logic       rdy_o [2];
    logic [7:0] s_o   [2];
    logic       ov_o  [2];
    logic       of_o  [2];
    logic       st_o  [2];
    logic [7:0] cnt0;
    logic [3:0] cnt1;

    int n_chk = 0;
    int n_fail = 0;

    int   m_s    [2];
    int   m_cnt  [2];
    bit   m_st   [2];
    bit   m_halt [2];
    bit   p_v    [2];
    bit   p_ovf  [2];
    bit   exp_rdy[2];
    exp_t q0[$];
    exp_t q1[$];

    const int cmod  [2] = '{256, 16};
    const bit halt_k[2] = '{1'b0, 1'b1};

    always #5 Clk = ~Clk;

    addsub_acc_pipe #(.WIDTH(8), .CNT_WIDTH(8), .HALT_ON_OF(0)) u0 (
        .Clk(Clk), .Resetn(Resetn), .In_valid(in_valid), .In_ready(rdy_o[0]),
        .Op(op_i), .A(a_i), .Clr_of(clr_of), .S(s_o[0]), .Out_valid(ov_o[0]),
        .OF(of_o[0]), .OF_sticky(st_o[0]), .Count(cnt0)
    );

    addsub_acc_pipe #(.WIDTH(8), .CNT_WIDTH(4), .HALT_ON_OF(1)) u1 (
        .Clk(Clk), .Resetn(Resetn), .In_valid(in_valid), .In_ready(rdy_o[1]),
        .Op(op_i), .A(a_i), .Clr_of(clr_of), .S(s_o[1]), .Out_valid(ov_o[1]),
        .OF(of_o[1]), .OF_sticky(st_o[1]), .Count(cnt1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accumulator kept as a plain integer, evaluated in acceptance order.
    always @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < 2; k++) begin
                m_s[k] = 0; m_cnt[k] = 0; m_st[k] = 0; m_halt[k] = 0;
                p_v[k] = 0; p_ovf[k] = 0; exp_rdy[k] = 1;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   av;
                int   r;
                bit   ovf;
                exp_t e;
                if (p_v[k] && p_ovf[k]) begin
                    m_st[k] = 1;
                    if (halt_k[k]) m_halt[k] = 1;
                end else if (clr_of) begin
                    m_st[k] = 0;
                    m_halt[k] = 0;
                end
                p_v[k] = 0;
                p_ovf[k] = 0;
                if (in_valid && exp_rdy[k]) begin
                    av  = int'($signed(a_i));
                    ovf = 0;
                    case (op_i)
                        LOAD: begin m_s[k] = av; m_cnt[k] = (m_cnt[k] + 1) % cmod[k]; end
                        CLR:  begin m_s[k] = 0;  m_cnt[k] = 0; end
                        default: begin
                            r = (op_i == ADD) ? m_s[k] + av : m_s[k] - av;
                            if (r > 127 || r < -128) begin
                                ovf = 1;
`ifdef ADDSUB_ACC_SAT_EN
                                r = (r > 127) ? 127 : -128;
`else
                                r = (r > 127) ? r - 256 : r + 256;
`endif
                            end
                            m_s[k] = r;
                            m_cnt[k] = (m_cnt[k] + 1) % cmod[k];
                        end
                    endcase
                    e.s = 8'(m_s[k]);
                    e.of = ovf;
                    e.cnt = m_cnt[k];
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                    p_v[k] = 1;
                    p_ovf[k] = ovf;
                end
                exp_rdy[k] = !m_halt[k] && !(halt_k[k] && p_v[k] && p_ovf[k]);
            end
        end
    end

    always @(negedge Clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("in_ready[%0d]", k), int'(rdy_o[k]), int'(Resetn && exp_rdy[k]));
            chk($sformatf("of_sticky[%0d]", k), int'(st_o[k]), int'(m_st[k]));
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (ov_o[0]) begin
            if (q0.size() == 0) chk("unexpected out_valid[0]", 1, 0);
            else begin
                e = q0.pop_front();
                chk("S[0]", int'(s_o[0]), int'(e.s));
                chk("OF[0]", int'(of_o[0]), int'(e.of));
                chk("Count[0]", int'(cnt0), e.cnt);
            end
        end
        if (q0.size() > 1) chk("missing out_valid[0]", q0.size(), 1);
    end

    always @(negedge Clk) begin
        exp_t e;
        if (ov_o[1]) begin
            if (q1.size() == 0) chk("unexpected out_valid[1]", 1, 0);
            else begin
                e = q1.pop_front();
                chk("S[1]", int'(s_o[1]), int'(e.s));
                chk("OF[1]", int'(of_o[1]), int'(e.of));
                chk("Count[1]", int'(cnt1), e.cnt);
            end
        end
        if (q1.size() > 1) chk("missing out_valid[1]", q1.size(), 1);
    end

    task automatic cyc(input bit v, input logic [1:0] op, input logic [7:0] a, input bit c);
        in_valid = v; op_i = op; a_i = a; clr_of = c;
        @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, ADD, 8'h00, 0);
    endtask

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s S[%0d]", tag, k), int'(s_o[k]), 0);
            chk($sformatf("%s OF[%0d]", tag, k), int'(of_o[k]), 0);
            chk($sformatf("%s sticky[%0d]", tag, k), int'(st_o[k]), 0);
            chk($sformatf("%s out_valid[%0d]", tag, k), int'(ov_o[k]), 0);
            chk($sformatf("%s in_ready[%0d]", tag, k), int'(rdy_o[k]), 0);
        end
        chk({tag, " Count[0]"}, int'(cnt0), 0);
        chk({tag, " Count[1]"}, int'(cnt1), 0);
    endtask

    initial begin
        logic [7:0] picks [6];
        picks = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h40};

        repeat (3) @(negedge Clk);
        chk_zero("reset");
        Resetn = 1'b1;

        cyc(1, LOAD, 8'h05, 0); cyc(1, ADD, 8'h03, 0); idle(2);
        cyc(1, LOAD, 8'h7F, 0); cyc(1, ADD, 8'h01, 0); idle(2);
        cyc(0, ADD, 8'h00, 1); idle(1);
        cyc(1, LOAD, 8'h00, 0); cyc(1, SUB, 8'h80, 0); idle(2);
        cyc(0, ADD, 8'h00, 1);
        cyc(1, LOAD, 8'h80, 0); cyc(1, SUB, 8'h01, 0); idle(2);
        cyc(0, ADD, 8'h00, 1);

        // Overflow lands mid-stream; the halting instance must refuse the rest.
        cyc(1, LOAD, 8'h7E, 0);
        for (int i = 0; i < 5; i++) cyc(1, ADD, 8'h01, 0);
        idle(2);
        cyc(0, ADD, 8'h00, 1); idle(1);

        // Clr_of coincident with an overflow retire leaves the sticky flag set.
        cyc(1, LOAD, 8'h7F, 0); cyc(1, ADD, 8'h01, 0); cyc(0, ADD, 8'h00, 1); idle(2);
        cyc(0, ADD, 8'h00, 1);

        cyc(1, CLR, 8'h55, 0);
        for (int i = 0; i < 17; i++) cyc(1, ADD, 8'h00, 0);
        cyc(1, CLR, 8'h00, 0); idle(2);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom % 2 == 0) ? picks[$urandom % 6] : 8'($urandom);
            cyc(($urandom % 4) != 0, 2'($urandom), a, ($urandom % 10) == 0);
        end
        idle(2);

        // Asynchronous reset with an op just accepted and in flight.
        cyc(1, LOAD, 8'h11, 0);
        in_valid = 1'b1; op_i = ADD; a_i = 8'h22;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        Resetn = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge Clk);
        @(negedge Clk);
        Resetn = 1'b1;
        idle(3);
        cyc(1, LOAD, 8'h09, 0); cyc(1, SUB, 8'h0A, 0); idle(3);

        chk("drain q0", q0.size(), 0);
        chk("drain q1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
